// File: rtl/decomp_digit_scheduler.sv
// decomp_digit_scheduler
// Schedules multi-digit RNS/base decomposition jobs onto the one shared
// vector decomposition unit. Requesters are arbitrated round-robin. Each
// accepted job gets one start_vector per digit, with its own shift (p),
// bit count (pq0) and buffer-RAM bank. The scheduler waits for the vector
// unit to drain before the next digit. The owner gets a done pulse at the end.
//
// Ports
//   clk, rst                : clock, asynchronous active-high reset
//   req_valid[NREQ]         : job request, held by requester until req_ready
//   req_ready[NREQ]         : one-cycle one-hot accept pulse
//   req_num_digits          : NREQ x DIGW, digits per job (0 = empty job)
//   req_digit_bits          : NREQ x FSIZE, bits per digit
//   req_base_bank           : NREQ x BANKW, bank holding digit 0
//   done[NREQ]              : one-cycle completion pulse to the job owner
//   start_vector            : start pulse to the vector unit
//   operation               : decomposition opcode while busy, else 0
//   p, pq0                  : per-digit shift amount and bit count
//   bank_sel                : buffer-RAM bank steered to the vector unit
//   vector_working          : busy flag from the vector unit
//   busy                    : job in progress (through its done pulse)
//   cur_owner, cur_digit    : owner and digit index of the current job
//
// Timing: every output is a register loaded from the next-state logic.
// start_vector, p, pq0, bank_sel and operation therefore line up with the
// ISSUE state. req_ready shows in the first cycle after the IDLE cycle that
// sampled req_valid. done shows in the cycle after FINISH. busy also covers
// that done cycle, so a zero-digit job holds busy for two cycles.
module decomp_digit_scheduler #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DIGW  = 4,
  parameter int unsigned BANKW = 3,
  parameter int unsigned FSIZE = 16,
  localparam int unsigned OWNW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*DIGW-1:0]  req_num_digits,
  input  logic [NREQ*FSIZE-1:0] req_digit_bits,
  input  logic [NREQ*BANKW-1:0] req_base_bank,
  output logic [NREQ-1:0]       done,
  output logic                  start_vector,
  output logic [3:0]            operation,
  output logic [FSIZE-1:0]      p,
  output logic [FSIZE-1:0]      pq0,
  output logic [BANKW-1:0]      bank_sel,
  input  logic                  vector_working,
  output logic                  busy,
  output logic [OWNW-1:0]       cur_owner,
  output logic [DIGW-1:0]       cur_digit
);

  localparam logic [3:0] VECTOR_OPERATION_DECOMP_REDUCTION = 4'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ARM,
    DRAIN,
    NEXT,
    FINISH
  } state_t;

  state_t state, state_n;

  // Latched job parameters and digit bookkeeping
  logic [OWNW-1:0]  rr_ptr, rr_n;
  logic [DIGW-1:0]  num_q, num_n;
  logic [FSIZE-1:0] bits_q, bits_n;
  logic [BANKW-1:0] base_q, base_n;
  logic [FSIZE-1:0] shift_acc, shift_n;
  logic [OWNW-1:0]  owner_n;
  logic [DIGW-1:0]  digit_n;

  // Next values of the registered outputs
  logic [NREQ-1:0]  ready_n;
  logic [NREQ-1:0]  done_n;
  logic             start_n;
  logic [3:0]       op_n;
  logic [FSIZE-1:0] p_n;
  logic [FSIZE-1:0] pq0_n;
  logic [BANKW-1:0] bank_n;
  logic             busy_n;

  // Arbitration
  logic             found;
  logic [OWNW-1:0]  gnt;
  logic [OWNW-1:0]  cand;

  // Per-requester views of the packed request fields
  logic [DIGW-1:0]  num_arr  [NREQ];
  logic [FSIZE-1:0] bits_arr [NREQ];
  logic [BANKW-1:0] base_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign num_arr[i]  = req_num_digits[i*DIGW +: DIGW];
    assign bits_arr[i] = req_digit_bits[i*FSIZE +: FSIZE];
    assign base_arr[i] = req_base_bank[i*BANKW +: BANKW];
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    owner_n = cur_owner;
    num_n   = num_q;
    bits_n  = bits_q;
    base_n  = base_q;
    shift_n = shift_acc;
    digit_n = cur_digit;
    ready_n = '0;
    done_n  = '0;
    start_n = 1'b0;
    p_n     = p;
    pq0_n   = pq0;
    bank_n  = bank_sel;
    found   = 1'b0;
    gnt     = '0;
    cand    = '0;

    // First valid requester at or after the round-robin pointer
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = OWNW'((32'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          ready_n[gnt] = 1'b1;
          owner_n      = gnt;
          num_n        = num_arr[gnt];
          bits_n       = bits_arr[gnt];
          base_n       = base_arr[gnt];
          rr_n         = (gnt == OWNW'(NREQ - 1)) ? '0 : gnt + OWNW'(1);
          shift_n      = '0;
          digit_n      = '0;
          state_n      = (num_arr[gnt] != '0) ? ISSUE : FINISH;
        end
      end
      ISSUE: state_n = ARM;
      // The unit raises vector_working one cycle after start, so skip a cycle.
      ARM:   state_n = DRAIN;
      DRAIN: begin
        if (!vector_working) state_n = NEXT;
      end
      NEXT: begin
        if (cur_digit == num_q - DIGW'(1)) begin
          state_n = FINISH;
        end else begin
          digit_n = cur_digit + DIGW'(1);
          shift_n = shift_acc + bits_q;
          state_n = ISSUE;
        end
      end
      FINISH: begin
        done_n[cur_owner] = 1'b1;
        state_n           = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Digit parameters are loaded on entry to ISSUE and held until the next one
    if (state_n == ISSUE) begin
      start_n = 1'b1;
      p_n     = shift_n;
      pq0_n   = bits_n;
      bank_n  = base_n + BANKW'(digit_n);
    end

    busy_n = (state_n != IDLE) || (state == FINISH);
    op_n   = busy_n ? VECTOR_OPERATION_DECOMP_REDUCTION : 4'd0;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      num_q        <= '0;
      bits_q       <= '0;
      base_q       <= '0;
      shift_acc    <= '0;
      cur_owner    <= '0;
      cur_digit    <= '0;
      req_ready    <= '0;
      done         <= '0;
      start_vector <= 1'b0;
      operation    <= 4'd0;
      p            <= '0;
      pq0          <= '0;
      bank_sel     <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      rr_ptr       <= rr_n;
      num_q        <= num_n;
      bits_q       <= bits_n;
      base_q       <= base_n;
      shift_acc    <= shift_n;
      cur_owner    <= owner_n;
      cur_digit    <= digit_n;
      req_ready    <= ready_n;
      done         <= done_n;
      start_vector <= start_n;
      operation    <= op_n;
      p            <= p_n;
      pq0          <= pq0_n;
      bank_sel     <= bank_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_decomp_digit_scheduler.sv
// Directed bench for decomp_digit_scheduler with a stub vector unit.
// The stub raises vector_working one cycle after start_vector and keeps it
// high for stub_len cycles. Cycle numbers count from 1 at the first
// posedge after the request is applied.
module tb_decomp_digit_scheduler;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned DIGW  = 4;
  localparam int unsigned BANKW = 3;
  localparam int unsigned FSIZE = 16;
  localparam logic [3:0] OP_DECOMP = 4'd3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*DIGW-1:0]  req_num_digits;
  logic [NREQ*FSIZE-1:0] req_digit_bits;
  logic [NREQ*BANKW-1:0] req_base_bank;
  logic [NREQ-1:0]       done;
  logic                  start_vector;
  logic [3:0]            operation;
  logic [FSIZE-1:0]      p;
  logic [FSIZE-1:0]      pq0;
  logic [BANKW-1:0]      bank_sel;
  logic                  vector_working;
  logic                  busy;
  logic [0:0]            cur_owner;
  logic [DIGW-1:0]       cur_digit;

  decomp_digit_scheduler #(
    .NREQ(NREQ), .DIGW(DIGW), .BANKW(BANKW), .FSIZE(FSIZE)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_num_digits(req_num_digits), .req_digit_bits(req_digit_bits),
    .req_base_bank(req_base_bank), .done(done),
    .start_vector(start_vector), .operation(operation),
    .p(p), .pq0(pq0), .bank_sel(bank_sel),
    .vector_working(vector_working), .busy(busy),
    .cur_owner(cur_owner), .cur_digit(cur_digit)
  );

  always #5 clk = ~clk;

  // Stub vector unit
  int unsigned stub_len;
  int unsigned vw_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)               vw_cnt <= 0;
    else if (start_vector) vw_cnt <= stub_len;
    else if (vw_cnt != 0)  vw_cnt <= vw_cnt - 1;
  end
  assign vector_working = (vw_cnt != 0);

  int total = 0;
  int bad   = 0;

  // Event records filled by run_job
  int               cyc;
  int               n_rdy, n_st, n_done, busy_cycles, fall_cyc;
  logic [NREQ-1:0]  rdy_vec  [8];
  int               rdy_cyc  [8];
  logic [FSIZE-1:0] st_p     [8];
  logic [FSIZE-1:0] st_pq0   [8];
  logic [BANKW-1:0] st_bank  [8];
  logic [DIGW-1:0]  st_dig   [8];
  logic [0:0]       st_own   [8];
  logic [3:0]       st_op    [8];
  int               st_cyc   [8];
  logic [NREQ-1:0]  done_vec [8];
  int               done_cyc [8];

  task automatic set_req(input int i, input logic [DIGW-1:0] nd,
                         input logic [FSIZE-1:0] bits, input logic [BANKW-1:0] bank);
    req_num_digits[i*DIGW +: DIGW]   = nd;
    req_digit_bits[i*FSIZE +: FSIZE] = bits;
    req_base_bank[i*BANKW +: BANKW]  = bank;
  endtask

  // Steps the clock, records handshakes/starts/done, drops valid on ready
  task automatic run_job(input int want_done, input int max_cycles, input int tail,
                         output bit ok);
    int   extra;
    logic vw_prev;
    extra = -1;
    n_rdy = 0; n_st = 0; n_done = 0; busy_cycles = 0; fall_cyc = -1; cyc = 0;
    vw_prev = vector_working;
    while (cyc < max_cycles && extra != 0) begin
      @(posedge clk); #1; cyc++;
      if (req_ready != '0) begin
        if (n_rdy < 8) begin rdy_vec[n_rdy] = req_ready; rdy_cyc[n_rdy] = cyc; end
        n_rdy++;
        req_valid = req_valid & ~req_ready;
      end
      if (start_vector) begin
        if (n_st < 8) begin
          st_p[n_st] = p; st_pq0[n_st] = pq0; st_bank[n_st] = bank_sel;
          st_dig[n_st] = cur_digit; st_own[n_st] = cur_owner;
          st_op[n_st] = operation; st_cyc[n_st] = cyc;
        end
        n_st++;
      end
      if (done != '0) begin
        if (n_done < 8) begin done_vec[n_done] = done; done_cyc[n_done] = cyc; end
        n_done++;
      end
      if (busy) busy_cycles++;
      if (vw_prev && !vector_working && fall_cyc < 0) fall_cyc = cyc;
      vw_prev = vector_working;
      if (extra > 0) extra--;
      else if (extra < 0 && n_done >= want_done) extra = tail;
    end
    ok = (n_done >= want_done);
  endtask

  task automatic test_reset();
    logic [49:0] outs;
    req_valid = '0; req_num_digits = '0; req_digit_bits = '0; req_base_bank = '0;
    stub_len = 0;
    rst = 1'b0; #1 rst = 1'b1; #1;
    outs = {req_ready, done, start_vector, operation, p, pq0, bank_sel, busy, cur_owner, cur_digit};
    total++; if (outs !== 50'd0) begin bad++; $display("FAIL reset_outputs got=%0h want=0", outs); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    total++; if ({busy, req_ready, start_vector} !== 4'b0) begin bad++;
      $display("FAIL idle_after_reset got=%0b want=0", {busy, req_ready, start_vector}); end
  endtask

  task automatic test_single_job();
    bit ok;
    set_req(0, 4'd3, 16'd20, 3'd1); stub_len = 10; req_valid = 2'b01;
    run_job(1, 200, 3, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d want=1 done", n_done); end
    total++; if (n_rdy !== 1 || rdy_vec[0] !== 2'b01 || rdy_cyc[0] !== 1) begin bad++;
      $display("FAIL single_ready got=n%0d v%b c%0d want=n1 v01 c1", n_rdy, rdy_vec[0], rdy_cyc[0]); end
    total++; if (n_st !== 3) begin bad++; $display("FAIL single_nstart got=%0d want=3", n_st); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (st_p[i] !== FSIZE'(20*i) || st_pq0[i] !== 16'd20 || st_bank[i] !== BANKW'(1+i) ||
          st_dig[i] !== DIGW'(i) || st_cyc[i] !== 1 + 13*i || st_op[i] !== OP_DECOMP) begin
        bad++;
        $display("FAIL single_digit%0d got=p%0d pq0%0d b%0d d%0d c%0d op%0d want=p%0d pq0 20 b%0d d%0d c%0d op3",
                 i, st_p[i], st_pq0[i], st_bank[i], st_dig[i], st_cyc[i], st_op[i], 20*i, 1+i, i, 1+13*i);
      end
    end
    total++; if (n_done !== 1 || done_vec[0] !== 2'b01 || done_cyc[0] !== 41) begin bad++;
      $display("FAIL single_done got=n%0d v%b c%0d want=n1 v01 c41", n_done, done_vec[0], done_cyc[0]); end
    total++; if (busy_cycles !== 41) begin bad++; $display("FAIL single_busy got=%0d want=41", busy_cycles); end
  endtask

  task automatic test_round_robin();
    bit ok;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_req(0, 4'd1, 16'd5, 3'd0); set_req(1, 4'd1, 16'd7, 3'd4);
    stub_len = 2; req_valid = 2'b11;
    run_job(2, 100, 0, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_timeout got=%0d want=2 done", n_done); end
    total++; if (rdy_vec[0] !== 2'b01 || rdy_cyc[0] !== 1 || rdy_vec[1] !== 2'b10 || rdy_cyc[1] !== 8) begin bad++;
      $display("FAIL rr_order got=%b@%0d %b@%0d want=01@1 10@8", rdy_vec[0], rdy_cyc[0], rdy_vec[1], rdy_cyc[1]); end
    total++; if (done_vec[0] !== 2'b01 || done_cyc[0] !== 7 || done_vec[1] !== 2'b10 || done_cyc[1] !== 14) begin bad++;
      $display("FAIL rr_done got=%b@%0d %b@%0d want=01@7 10@14", done_vec[0], done_cyc[0], done_vec[1], done_cyc[1]); end
    total++; if (st_own[1] !== 1'b1 || st_pq0[1] !== 16'd7 || st_bank[1] !== 3'd4 || st_p[1] !== 16'd0) begin bad++;
      $display("FAIL rr_job1 got=o%0d pq0 %0d b%0d p%0d want=o1 pq0 7 b4 p0", st_own[1], st_pq0[1], st_bank[1], st_p[1]); end
    req_valid = 2'b11;
    run_job(2, 100, 0, ok);
    total++; if (!ok || rdy_vec[0] !== 2'b01 || rdy_vec[1] !== 2'b10) begin bad++;
      $display("FAIL rr_second_round got=ok%0d %b %b want=ok1 01 10", ok, rdy_vec[0], rdy_vec[1]); end
  endtask

  task automatic test_zero_digit();
    bit ok;
    set_req(1, 4'd0, 16'd9, 3'd2); stub_len = 5; req_valid = 2'b10;
    run_job(1, 20, 3, ok);
    total++; if (!ok || rdy_vec[0] !== 2'b10 || rdy_cyc[0] !== 1) begin bad++;
      $display("FAIL zero_ready got=ok%0d %b@%0d want=ok1 10@1", ok, rdy_vec[0], rdy_cyc[0]); end
    total++; if (done_vec[0] !== 2'b10 || done_cyc[0] !== 2) begin bad++;
      $display("FAIL zero_done got=%b@%0d want=10@2", done_vec[0], done_cyc[0]); end
    total++; if (n_st !== 0) begin bad++; $display("FAIL zero_nostart got=%0d want=0", n_st); end
    total++; if (busy_cycles !== 2) begin bad++; $display("FAIL zero_busy got=%0d want=2", busy_cycles); end
  endtask

  task automatic test_bank_wrap();
    bit ok;
    set_req(0, 4'd3, 16'd3, 3'd7); stub_len = 0; req_valid = 2'b01;
    run_job(1, 60, 0, ok);
    total++; if (!ok || n_st !== 3) begin bad++; $display("FAIL wrap_nstart got=ok%0d n%0d want=ok1 n3", ok, n_st); end
    total++; if (st_bank[0] !== 3'd7 || st_bank[1] !== 3'd0 || st_bank[2] !== 3'd1) begin bad++;
      $display("FAIL wrap_banks got=%0d,%0d,%0d want=7,0,1", st_bank[0], st_bank[1], st_bank[2]); end
    total++; if (st_p[2] !== 16'd6 || st_cyc[1] !== 5 || st_cyc[2] !== 9 || done_cyc[0] !== 14) begin bad++;
      $display("FAIL wrap_timing got=p%0d c%0d c%0d d%0d want=p6 c5 c9 d14", st_p[2], st_cyc[1], st_cyc[2], done_cyc[0]); end
  endtask

  task automatic test_long_busy();
    bit ok;
    set_req(0, 4'd2, 16'd8, 3'd0); stub_len = 50; req_valid = 2'b01;
    run_job(1, 300, 0, ok);
    total++; if (!ok || n_st !== 2) begin bad++; $display("FAIL long_nstart got=ok%0d n%0d want=ok1 n2", ok, n_st); end
    total++; if (fall_cyc !== 52 || st_cyc[1] !== 54) begin bad++;
      $display("FAIL long_restart got=fall%0d start%0d want=fall52 start54", fall_cyc, st_cyc[1]); end
    total++; if (st_p[1] !== 16'd8 || st_dig[1] !== 4'd1) begin bad++;
      $display("FAIL long_digit1 got=p%0d d%0d want=p8 d1", st_p[1], st_dig[1]); end
  endtask

  task automatic test_reset_mid_job();
    bit ok;
    int starts, n;
    logic [49:0] outs;
    int stray;
    set_req(0, 4'd3, 16'd10, 3'd0); stub_len = 20; req_valid = 2'b01;
    starts = 0; n = 0;
    while (starts < 2 && n < 100) begin
      @(posedge clk); #1; n++;
      if (req_ready != '0) req_valid = req_valid & ~req_ready;
      if (start_vector) starts++;
    end
    total++; if (starts !== 2) begin bad++; $display("FAIL rstmid_reach got=%0d want=2 starts", starts); end
    repeat (3) @(posedge clk);
    #2 rst = 1'b1; #1;
    outs = {req_ready, done, start_vector, operation, p, pq0, bank_sel, busy, cur_owner, cur_digit};
    total++; if (outs !== 50'd0) begin bad++; $display("FAIL rstmid_outputs got=%0h want=0", outs); end
    stray = 0;
    repeat (2) begin @(posedge clk); #1; if (done != '0) stray++; end
    @(negedge clk) rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done != '0 || busy) stray++; end
    total++; if (stray !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", stray); end
    set_req(1, 4'd2, 16'd4, 3'd2); stub_len = 1; req_valid = 2'b10;
    run_job(1, 60, 0, ok);
    total++; if (!ok || rdy_vec[0] !== 2'b10 || done_vec[0] !== 2'b10) begin bad++;
      $display("FAIL rstmid_newjob got=ok%0d r%b d%b want=ok1 r10 d10", ok, rdy_vec[0], done_vec[0]); end
    total++; if (st_dig[0] !== 4'd0 || st_p[0] !== 16'd0 || st_bank[0] !== 3'd2 || st_own[0] !== 1'b1) begin bad++;
      $display("FAIL rstmid_first got=d%0d p%0d b%0d o%0d want=d0 p0 b2 o1", st_dig[0], st_p[0], st_bank[0], st_own[0]); end
    total++; if (st_p[1] !== 16'd4 || st_bank[1] !== 3'd3 || st_cyc[1] !== 5) begin bad++;
      $display("FAIL rstmid_second got=p%0d b%0d c%0d want=p4 b3 c5", st_p[1], st_bank[1], st_cyc[1]); end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_zero_digit();
    test_bank_wrap();
    test_long_busy();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
